// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, baud codes and the transmit scheduler state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int BAUD_W      = 3;

    localparam logic [BAUD_W-1:0] BAUD_9600   = 3'b000;
    localparam logic [BAUD_W-1:0] BAUD_19200  = 3'b001;
    localparam logic [BAUD_W-1:0] BAUD_38400  = 3'b010;
    localparam logic [BAUD_W-1:0] BAUD_57600  = 3'b011;
    localparam logic [BAUD_W-1:0] BAUD_115200 = 3'b100;
    localparam logic [BAUD_W-1:0] BAUD_230400 = 3'b101;
    localparam logic [BAUD_W-1:0] BAUD_460800 = 3'b110;
    localparam logic [BAUD_W-1:0] BAUD_921600 = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BAUD       = 3'd1,
        ST_WRITE      = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester strictly after `last`
// wins, falling back to the lowest requester when none lies above it.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int IW = $clog2(N_REQ);

    logic found;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves a value held (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // Upper slice: requesters above the previous winner.
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i > int'(last))) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                found     = 1'b1;
            end
        end
        // Wrap-around: lowest requester overall.
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_RT transmitter among N_REQ byte producers: round-robin grant,
// one frame at a time, and baud code changes applied only between frames.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [BAUD_W-1:0]            cfg_baud,
    output logic [BAUD_W-1:0]            baud_select,
    output logic                         Tx_EN,
    output logic                         Tx_WR,
    output logic [UART_DATA_W-1:0]       Tx_DATA,
    input  logic                         Tx_BUSY,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         idle,
    output logic                         tx_timeout
);

    localparam int            IW       = $clog2(N_REQ);
    localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    tx_state_e              state;
    logic [IW-1:0]          last;
    logic [CW-1:0]          wait_cnt;
    logic [N_REQ-1:0]       arb_grant;
    logic [IW-1:0]          arb_idx;
    logic [UART_DATA_W-1:0] sel_data;
    logic                   baud_change;
    logic                   grant_ok;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req      (req_valid),
        .last     (last),
        .grant    (arb_grant),
        .grant_idx(arb_idx)
    );

    // A pending baud change outranks requests; reset masks the accept strobe.
    assign baud_change = (cfg_baud != baud_select);
    assign grant_ok    = (state == ST_IDLE) && !baud_change && !Tx_BUSY
                         && (|req_valid) && reset;
    assign req_ready   = grant_ok ? arb_grant : '0;
    assign idle        = (state == ST_IDLE) && !Tx_BUSY;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_data = req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    // NOTE: state and output registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            last        <= IW'(N_REQ - 1);
            wait_cnt    <= '0;
            baud_select <= BAUD_9600;
            Tx_EN       <= 1'b0;
            Tx_WR       <= 1'b0;
            Tx_DATA     <= '0;
            grant_id    <= '0;
            tx_timeout  <= 1'b0;
        end else begin
            Tx_WR      <= 1'b0;
            tx_timeout <= 1'b0;
            Tx_EN      <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (baud_change) begin
                        state <= ST_BAUD;
                        Tx_EN <= 1'b0;
                    end else if (grant_ok) begin
                        Tx_DATA  <= sel_data;
                        grant_id <= arb_idx;
                        last     <= arb_idx;
                        Tx_WR    <= 1'b1;
                        state    <= ST_WRITE;
                    end
                end
                ST_BAUD: begin
                    baud_select <= cfg_baud;
                    state       <= ST_IDLE;
                end
                ST_WRITE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    // An unanswered write is dropped, never retried.
                    if (Tx_BUSY) begin
                        state <= ST_WAIT_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        tx_timeout <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a uart_RT model drives Tx_BUSY, expected
// frames come from a queue-level round-robin model, a monitor compares on Tx_WR.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int N  = 2;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [2:0]     cfg_baud;
    logic [2:0]     baud_select;
    logic           Tx_EN, Tx_WR, Tx_BUSY, idle, tx_timeout;
    logic [7:0]     Tx_DATA;
    logic [IW-1:0]  grant_id;

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cfg_baud   (cfg_baud),
        .baud_select(baud_select),
        .Tx_EN      (Tx_EN),
        .Tx_WR      (Tx_WR),
        .Tx_DATA    (Tx_DATA),
        .Tx_BUSY    (Tx_BUSY),
        .grant_id   (grant_id),
        .idle       (idle),
        .tx_timeout (tx_timeout)
    );

    typedef struct {
        int         gid;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[N][$];
    int         n_cmp      = 0;
    int         n_err      = 0;
    int         model_last = N - 1;
    bit         uart_stuck = 1'b0;
    int         lat_max    = 3;
    int         len_min    = 2;
    int         len_max    = 6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first valid index after the last winner, modulo N.
    function automatic int rr_pick(input logic [N-1:0] v);
        for (int off = 1; off <= N; off++) begin
            if (v[(model_last + off) % N]) return (model_last + off) % N;
        end
        return -1;
    endfunction

    task automatic expect_frame(input logic [N-1:0] v, input logic [8*N-1:0] d, output int w);
        exp_t e;
        w      = rr_pick(v);
        e.gid  = w;
        e.data = d[8*w +: 8];
        exp_q.push_back(e);
        model_last = w;
    endtask

    task automatic wait_hs(input string name, input int budget, output logic [N-1:0] hs);
        hs = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if (hs != '0) return;
        end
        check(name, 32'(|hs), 1);
    endtask

    task automatic wait_busy(input logic lvl, input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (Tx_BUSY === lvl) return;
        end
        check(name, Tx_BUSY, lvl);
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (idle === 1'b1) return;
        end
        check(name, idle, 1);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]     = (src_q[i].size() != 0);
            req_data[8*i +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    function automatic int remaining();
        int r = 0;
        for (int i = 0; i < N; i++) r += src_q[i].size();
        return r;
    endfunction

    // uart_RT model: Tx_BUSY rises a random latency after Tx_WR and stays high a random frame length.
    initial begin : uart_model
        int         start_wait;
        int         busy_left;
        logic [7:0] held;
        Tx_BUSY    = 1'b0;
        start_wait = -1;
        busy_left  = 0;
        held       = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b1) begin
                Tx_BUSY    = 1'b0;
                start_wait = -1;
                busy_left  = 0;
            end else begin
                if (Tx_BUSY) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        Tx_BUSY = 1'b0;
                        check("tx_data_hold", Tx_DATA, held);
                    end
                end else if (start_wait > 0) begin
                    start_wait--;
                end else if (start_wait == 0) begin
                    Tx_BUSY    = 1'b1;
                    busy_left  = $urandom_range(len_max, len_min);
                    start_wait = -1;
                end
                if (Tx_WR && !uart_stuck) begin
                    start_wait = $urandom_range(lat_max, 0);
                    held       = Tx_DATA;
                end
            end
        end
    end

    initial begin : monitor
        logic prev_wr;
        exp_t e;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("ready_legal", 32'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 1);
                if (Tx_WR) begin
                    check("wr_width", prev_wr, 0);
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_wr", Tx_WR, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_grant_id", grant_id, e.gid);
                        check("sb_tx_data", Tx_DATA, e.data);
                    end
                end
                prev_wr = Tx_WR;
            end else begin
                prev_wr = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [N-1:0]   hs;
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        logic [7:0]     cp[N][$];
        int             w;
        int             n;

        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        cfg_baud  = BAUD_9600;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_req_ready", req_ready, 0);
            check("rst_tx_en", Tx_EN, 0);
            check("rst_tx_wr", Tx_WR, 0);
            check("rst_tx_data", Tx_DATA, 0);
            check("rst_baud_select", baud_select, 0);
            check("rst_grant_id", grant_id, 0);
            check("rst_tx_timeout", tx_timeout, 0);
            check("rst_idle", idle, 1);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rel_tx_en_same_cycle", Tx_EN, 0);
        @(negedge clk);
        check("rel_tx_en", Tx_EN, 1);
        check("rel_idle", idle, 1);

        // Contention: both requesters valid for four frames.
        tick();
        req_data  = {8'hB2, 8'hA1};
        req_valid = 2'b11;
        for (int f = 0; f < 4; f++) begin
            expect_frame(2'b11, req_data, w);
            wait_hs("cont_hs", 60, hs);
            check("cont_ready", hs, 32'(1) << w);
            tick();
            if (f == 3) req_valid = '0;
        end
        wait_idle("cont_idle", 60);

        // Single frame with a simultaneous baud change.
        tick();
        cfg_baud       = BAUD_115200;
        req_valid      = 2'b01;
        req_data[7:0]  = 8'h78;
        expect_frame(2'b01, req_data, w);
        @(negedge clk);
        check("sf_ready_before_baud", req_ready, 0);
        check("sf_en_idle", Tx_EN, 1);
        @(negedge clk);
        check("sf_en_in_baud", Tx_EN, 0);
        check("sf_ready_in_baud", req_ready, 0);
        @(negedge clk);
        check("sf_ready", req_ready, 2'b01);
        check("sf_baud_select", baud_select, BAUD_115200);
        check("sf_en_restored", Tx_EN, 1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("sf_wr", Tx_WR, 1);
        check("sf_data", Tx_DATA, 8'h78);
        @(negedge clk);
        check("sf_wr_drop", Tx_WR, 0);
        wait_busy(1'b1, "sf_busy_rise", 20);
        wait_busy(1'b0, "sf_busy_fall", 20);
        check("sf_idle_at_fall", idle, 0);
        @(negedge clk);
        check("sf_idle_after", idle, 1);

        // Timeout: transmitter never answers.
        uart_stuck = 1'b1;
        tick();
        req_valid      = 2'b10;
        req_data[15:8] = 8'h5C;
        expect_frame(2'b10, req_data, w);
        wait_hs("to_hs", 10, hs);
        check("to_ready", hs, 32'(1) << w);
        tick();
        req_valid = '0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (tx_timeout === 1'b1) break;
        end
        check("to_latency", n, 18);
        check("to_idle", idle, 1);
        @(negedge clk);
        check("to_pulse_width", tx_timeout, 0);
        uart_stuck = 1'b0;

        // Baud change while the frame is in flight.
        lat_max = 0;
        len_min = 6;
        len_max = 6;
        tick();
        req_valid     = 2'b01;
        req_data[7:0] = 8'hC3;
        expect_frame(2'b01, req_data, w);
        wait_hs("bm_hs", 10, hs);
        tick();
        req_valid = '0;
        wait_busy(1'b1, "bm_busy_rise", 20);
        tick();
        cfg_baud = BAUD_57600;
        @(negedge clk);
        check("bm_hold", baud_select, BAUD_115200);
        wait_busy(1'b0, "bm_busy_fall", 20);
        check("bm_hold_end", baud_select, BAUD_115200);
        check("bm_en_at_fall", Tx_EN, 1);
        @(negedge clk);
        check("bm_en_idle", Tx_EN, 1);
        check("bm_sel_idle", baud_select, BAUD_115200);
        @(negedge clk);
        check("bm_en_low", Tx_EN, 0);
        @(negedge clk);
        check("bm_en_back", Tx_EN, 1);
        check("bm_applied", baud_select, BAUD_57600);

        // Reset during WAIT_DONE with requests pending.
        tick();
        req_valid      = 2'b10;
        req_data[15:8] = 8'h5A;
        expect_frame(2'b10, req_data, w);
        wait_hs("rm_hs_first", 10, hs);
        tick();
        req_valid     = 2'b11;
        req_data[7:0] = 8'h11;
        wait_busy(1'b1, "rm_busy_rise", 20);
        tick();
        reset = 1'b0;
        #1;
        check("rm_tx_en", Tx_EN, 0);
        check("rm_tx_wr", Tx_WR, 0);
        check("rm_tx_data", Tx_DATA, 0);
        check("rm_grant_id", grant_id, 0);
        check("rm_baud_select", baud_select, 0);
        check("rm_req_ready", req_ready, 0);
        check("rm_tx_timeout", tx_timeout, 0);
        model_last = N - 1;
        @(negedge clk);
        @(negedge clk);
        check("rm_idle_in_reset", idle, 1);
        check("rm_ready_in_reset", req_ready, 0);
        check("rm_timeout_in_reset", tx_timeout, 0);
        tick();
        reset = 1'b1;
        expect_frame(2'b11, req_data, w);
        wait_hs("rm_hs_after", 10, hs);
        check("rm_ready_after", hs, 32'(1) << w);
        tick();
        req_valid = '0;
        wait_idle("rm_idle", 40);

        // Randomized rounds: random queue depths, bytes, baud codes and transmitter timing.
        lat_max = 3;
        len_min = 2;
        len_max = 6;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                src_q[i].delete();
                n = $urandom_range(4, 1);
                for (int k = 0; k < n; k++) src_q[i].push_back(8'($urandom));
                cp[i] = src_q[i];
            end
            while (1) begin
                v = '0;
                d = '0;
                for (int i = 0; i < N; i++) begin
                    if (cp[i].size() != 0) begin
                        v[i]       = 1'b1;
                        d[8*i +: 8] = cp[i][0];
                    end
                end
                if (v == '0) break;
                expect_frame(v, d, w);
                void'(cp[w].pop_front());
            end
            tick();
            cfg_baud = 3'($urandom);
            drive_reqs();
            for (int c = 0; c < 600 && remaining() > 0; c++) begin
                @(negedge clk);
                hs = req_valid & req_ready;
                tick();
                for (int i = 0; i < N; i++) begin
                    if (hs[i]) void'(src_q[i].pop_front());
                end
                drive_reqs();
            end
            check("rnd_drained", remaining(), 0);
            wait_idle("rnd_idle", 60);
            check("rnd_baud", baud_select, cfg_baud);
        end

        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
